// File: rtl/decode_pkg.sv
// Shared opcodes, format encoding and buffered-entry layout for the decode stage.
package decode_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  // pc/imm sized for the widest XLEN; the stage truncates to its own XLEN.
  typedef struct packed {
    logic [63:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    fmt_e        fmt;
    logic [63:0] imm;
    logic        illegal;
  } entry_t;

endpackage

// File: rtl/decode_imm_gen.sv
// Combinational immediate generator: sign-extends the format's immediate to XLEN.
module decode_imm_gen
  import decode_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:7]     instr,
  input  fmt_e            fmt,
  output logic [XLEN-1:0] imm
);

  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I: imm = XLEN'($signed(instr[31:20]));
      FMT_S: imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      FMT_B: imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      FMT_U: imm = XLEN'($signed({instr[31:12], 12'b0}));
      FMT_J: imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Registered RISC-V decode stage with a 2-entry skid buffer.
// Define DECODE_STAGE_RVM_EN to accept the OP MUL/DIV family (funct7=0000001).
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal
);

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  fmt_e            fmt;
  logic            illegal;
  logic [XLEN-1:0] imm;
  entry_t          dec;
  entry_t          main_q, skid_q;
  logic            main_v, skid_v;

  assign opcode = in_instr[6:0];
  assign f3     = in_instr[14:12];
  assign f7     = in_instr[31:25];

  always_comb begin
    illegal = 1'b0;
    fmt     = FMT_R;
    if (in_instr[1:0] != 2'b11) begin
      illegal = 1'b1;
    end else begin
      case (opcode)
        OPC_LUI, OPC_AUIPC: fmt = FMT_U;
        OPC_JAL:            fmt = FMT_J;
        OPC_JALR: begin
          fmt     = FMT_I;
          illegal = (f3 != 3'b000);
        end
        OPC_BRANCH: begin
          fmt     = FMT_B;
          illegal = (f3 == 3'b010) || (f3 == 3'b011);
        end
        OPC_LOAD: begin
          fmt = FMT_I;
          case (f3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: illegal = 1'b0;
            3'b011, 3'b110:                         illegal = (XLEN != 64);
            default:                                illegal = 1'b1;
          endcase
        end
        OPC_STORE: begin
          fmt = FMT_S;
          case (f3)
            3'b000, 3'b001, 3'b010: illegal = 1'b0;
            3'b011:                 illegal = (XLEN != 64);
            default:                illegal = 1'b1;
          endcase
        end
        OPC_MISC_MEM, OPC_SYSTEM: fmt = FMT_I;
        OPC_OP_IMM: begin
          fmt = FMT_I;
          // On RV32 the shift-immediate funct7 must be a real shift encoding.
          if (XLEN == 32) begin
            if (f3 == 3'b001 && f7 != F7_BASE)
              illegal = 1'b1;
            if (f3 == 3'b101 && f7 != F7_BASE && f7 != F7_ALT)
              illegal = 1'b1;
          end
        end
        OPC_OP: begin
          fmt = FMT_R;
          if (f7 == F7_BASE)
            illegal = 1'b0;
          else if (f7 == F7_ALT)
            illegal = !((f3 == 3'b000) || (f3 == 3'b101));
`ifdef DECODE_STAGE_RVM_EN
          else if (f7 == F7_MULDIV)
            illegal = 1'b0;
          else
            illegal = 1'b1;
`else
          else
            illegal = 1'b1;
`endif
        end
        default: illegal = 1'b1;
      endcase
    end
    if (illegal)
      fmt = FMT_R;
  end

  decode_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (in_instr[31:7]),
    .fmt   (fmt),
    .imm   (imm)
  );

  always_comb begin
    dec         = '0;
    dec.pc      = 64'(in_pc);
    dec.opcode  = opcode;
    dec.funct3  = f3;
    dec.funct7  = f7;
    dec.rs1     = in_instr[19:15];
    dec.rs2     = in_instr[24:20];
    dec.rd      = in_instr[11:7];
    dec.fmt     = fmt;
    dec.imm     = 64'(imm);
    dec.illegal = illegal;
  end

  // in_ready is the inverse of the skid flop, so it never depends on out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (!main_v || out_ready) begin
      if (skid_v) begin
        main_q <= skid_q;
        main_v <= 1'b1;
        skid_v <= 1'b0;
      end else begin
        main_v <= in_valid;
        if (in_valid)
          main_q <= dec;
      end
    end else if (in_valid && !skid_v) begin
      skid_q <= dec;
      skid_v <= 1'b1;
    end
  end

  assign in_ready    = ~skid_v;
  assign out_valid   = main_v;
  assign out_pc      = main_q.pc[XLEN-1:0];
  assign out_opcode  = main_q.opcode;
  assign out_funct3  = main_q.funct3;
  assign out_funct7  = main_q.funct7;
  assign out_rs1     = main_q.rs1;
  assign out_rs2     = main_q.rs2;
  assign out_rd      = main_q.rd;
  assign out_fmt     = main_q.fmt;
  assign out_imm     = main_q.imm[XLEN-1:0];
  assign out_illegal = main_q.illegal;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered RISC-V decode pipeline stage, parametrised in XLEN. Sits between fetch and execute.
- Accepts one 32-bit instruction plus its PC per valid/ready handshake.
- Extracts register and function fields, and produces a fully sign-extended XLEN-wide immediate selected by instruction format.
- Flags illegal encodings. A 2-entry skid buffer gives full throughput with registered in_ready.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64. Affects immediate width, PC width and load/store legality.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discard all buffered instructions
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept; registered
- in_instr  in  32  raw instruction
- in_pc  in  XLEN  instruction address
- out_valid  out  1  decoded entry valid
- out_ready  in  1  downstream accepts
- out_pc  out  XLEN  passthrough PC
- out_opcode  out  7  instr[6:0]
- out_funct3  out  3  instr[14:12]
- out_funct7  out  7  instr[31:25]
- out_rs1 / out_rs2 / out_rd  out  5 each  register indices
- out_fmt  out  3  format code (R,I,S,B,U,J)
- out_imm  out  XLEN  sign-extended immediate
- out_illegal  out  1  encoding not supported

Behaviour:
- Reset: out_valid=0, in_ready=1, skid entry empty, all data outputs 0.
- Transfer rules:
  - Input transfer on in_valid&in_ready.
  - Output transfer on out_valid&out_ready.
- Latency: exactly 1 cycle from input transfer to out_valid when the output register is empty or draining.
- Two entries, main (drives outputs) and skid:
  - Input transfer while main is full and not draining: data goes to skid.
  - Main drains while skid is full: skid moves to main.
  - in_ready (registered) = skid empty.
- Ordering: strict FIFO; no drop, no duplication.
- out_* fields must hold stable while out_valid=1 and out_ready=0.
- flush:
  - Next cycle, both entries are empty, out_valid=0, in_ready=1.
  - An input transfer in the same cycle as flush is discarded.
  - flush has priority over all other events; rst has priority over flush.
- Immediate generation (decoded at input and stored in the entry):
  - I: instr[31:20] sign-extended.
  - S: {instr[31:25],instr[11:7]} sign-extended.
  - B: {instr[31],instr[7],instr[30:25],instr[11:8],1'b0} sign-extended.
  - U: {instr[31:12],12'b0} sign-extended.
  - J: {instr[31],instr[19:12],instr[20],instr[30:21],1'b0} sign-extended.
  - R: imm=0.
- Format by opcode:
  - LUI/AUIPC → U
  - JAL → J
  - JALR, LOAD, OP-IMM, MISC-MEM, SYSTEM → I
  - STORE → S
  - BRANCH → B
  - OP → R
- out_illegal=1, with fmt=R and imm=0, when any of these holds:
  - instr[1:0]≠2'b11
  - unknown opcode
  - JALR with funct3≠000
  - BRANCH with funct3 010/011
  - LOAD funct3 not in {000,001,010,100,101}, plus {011,110} when XLEN=64
  - STORE funct3 not in {000,001,010}, plus 011 when XLEN=64
  - OP funct7 not 0000000, except 0100000 with funct3 000/101
  - OP-IMM funct3 001 with funct7≠0 (XLEN=32)
  - OP-IMM funct3 101 with funct7 not 0000000/0100000 (XLEN=32)
- An illegal instruction still flows through normally; this stage does not trap.

Optional Feature:
- Macro: DECODE_STAGE_RVM_EN.
- Defined: OP opcode with funct7=0000001 (MUL/DIV family, all funct3) is legal, fmt=R.
- Undefined: that encoding asserts out_illegal.

Decomposition:
- decode_pkg holds:
  - opcode localparams
  - fmt_e enum: R=0, I=1, S=2, B=3, U=4, J=5
  - decoded-entry packed struct (pc, fields, fmt, imm, illegal), used for both buffer entries
- One sub-module, decode_imm_gen: combinational; instr and fmt in, XLEN imm out, parametrised on XLEN.

Test Plan:
- 0xFFF00093 (addi x1,x0,-1), XLEN=32 → next cycle out_valid=1, rd=1, rs1=0, fmt=I, imm=0xFFFFFFFF, illegal=0.
- 0xFE000EE3 (beq x0,x0,-4) → fmt=B, imm=0xFFFFFFFC. With XLEN=64 → imm=0xFFFFFFFFFFFFFFFC.
- 0x123452B7 (lui x5,0x12345) → fmt=U, rd=5, imm=0x12345000. Then 0x00000000 → illegal=1.
- Stream 3 instructions with out_ready=0 → in_ready=0 after the 2nd acceptance. Raise out_ready → all 3 emerge in order, each stable while stalled.
- Both entries full, assert flush with in_valid=1 → next cycle out_valid=0, in_ready=1, no flushed or same-cycle instruction ever appears.
- 0x023100B3 (mul x1,x2,x3) → illegal=0 with DECODE_STAGE_RVM_EN defined, illegal=1 without.
